// File: rtl/sd_block_writer.sv
// Purpose: writes one 512-byte block to an SPI-mode SD card (CMD24 single-block write).
// Latency: (525 + nR1 + nBusy) bytes of 16*CLK_DIV clk each, from accepted start to done/error.
// Backpressure: start is ignored while busy=1 and in the cycle that done or error pulses.
// Ports: start/sector request a write; byteIndex/byteData fetch payload (1-cycle source latency);
//        busy/done/error/errCode report status; sdClk/sdMosi/sdMiso/sdCs form the SPI mode 0 bus.
module sd_block_writer #(
    parameter int CLK_DIV       = 2,
    parameter int R1_POLL_MAX   = 8,
    parameter int BUSY_POLL_MAX = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] sector,
    output logic [8:0]  byteIndex,
    input  logic [7:0]  byteData,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [2:0]  errCode,
    output logic        sdClk,
    output logic        sdMosi,
    input  logic        sdMiso,
    output logic        sdCs
);

    localparam logic [7:0]  DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [15:0] R1_LAST   = 16'(R1_POLL_MAX - 1);
    localparam logic [15:0] BUSY_LAST = 16'(BUSY_POLL_MAX - 1);

    typedef enum logic [3:0] {
        IDLE, PRE, CMD, R1, GAP, TOKEN, DATA, CRC, DRESP, BUSY, FINISH
    } state_t;

    state_t      state, state_n;
    logic [15:0] cnt;
    logic [31:0] sec_q;
    logic [2:0]  err_pend;

    // byte shifter
    logic        active;
    logic [7:0]  div;
    logic [2:0]  bitc;
    logic [7:0]  sh;
    logic [7:0]  rx;
    logic        byte_end;

    // FSM control
    logic        load, cnt_clr, cnt_inc, idx_inc, pend_set, accept, fin_ok, fin_err;
    logic [7:0]  tx, cmd_next;
    logic [2:0]  pend_code;

    // End of the high phase of bit 7: rx holds the complete received byte.
    assign byte_end = active && sdClk && (div == DIV_LAST) && (bitc == 3'd7);
    assign sdMosi   = active ? sh[7] : 1'b1;
    assign busy     = (state != IDLE);

    // Command byte following the one currently on the wire (cnt = current index).
    always_comb begin
        case (cnt[2:0])
            3'd0:    cmd_next = sec_q[31:24];
            3'd1:    cmd_next = sec_q[23:16];
            3'd2:    cmd_next = sec_q[15:8];
            3'd3:    cmd_next = sec_q[7:0];
            default: cmd_next = 8'hFF;
        endcase
    end

    // Every continuing state loads its next byte in the byte_end cycle so bytes run back to back.
    always_comb begin
        state_n   = state;
        load      = 1'b0;
        tx        = 8'hFF;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        idx_inc   = 1'b0;
        pend_set  = 1'b0;
        pend_code = 3'd0;
        fin_ok    = 1'b0;
        fin_err   = 1'b0;
        accept    = (state == IDLE) && start && !done && !error;
        case (state)
            IDLE: if (accept) begin
                state_n = PRE;
                load    = 1'b1;
            end
            PRE: if (byte_end) begin
                state_n = CMD;
                load    = 1'b1;
                tx      = 8'h58;
                cnt_clr = 1'b1;
            end
            CMD: if (byte_end) begin
                load = 1'b1;
                if (cnt == 16'd5) begin
                    state_n = R1;
                    cnt_clr = 1'b1;
                end else begin
                    tx      = cmd_next;
                    cnt_inc = 1'b1;
                end
            end
            R1: if (byte_end) begin
                load = 1'b1;
                if (!rx[7]) begin
                    if (rx == 8'h00) begin
                        state_n = GAP;
                    end else begin
                        state_n   = FINISH;
                        pend_set  = 1'b1;
                        pend_code = 3'd2;
                    end
                end else if (cnt == R1_LAST) begin
                    state_n   = FINISH;
                    pend_set  = 1'b1;
                    pend_code = 3'd1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            GAP: if (byte_end) begin
                state_n = TOKEN;
                load    = 1'b1;
                tx      = 8'hFE;
            end
            TOKEN: if (byte_end) begin
                state_n = DATA;
                load    = 1'b1;
                tx      = byteData;
                cnt_clr = 1'b1;
                idx_inc = 1'b1;
            end
            DATA: if (byte_end) begin
                load = 1'b1;
                if (cnt == 16'd511) begin
                    state_n = CRC;
                    cnt_clr = 1'b1;
                end else begin
                    tx      = byteData;
                    cnt_inc = 1'b1;
                    idx_inc = 1'b1;
                end
            end
            CRC: if (byte_end) begin
                load = 1'b1;
                if (cnt == 16'd1) state_n = DRESP;
                else              cnt_inc = 1'b1;
            end
            DRESP: if (byte_end) begin
                load = 1'b1;
                if (rx[4:0] == 5'h05) begin
                    state_n = BUSY;
                    cnt_clr = 1'b1;
                end else begin
                    state_n   = FINISH;
                    pend_set  = 1'b1;
                    pend_code = 3'd3;
                end
            end
            BUSY: if (byte_end) begin
                load = 1'b1;
                if (rx != 8'h00) begin
                    state_n = FINISH;
                end else if (cnt == BUSY_LAST) begin
                    state_n   = FINISH;
                    pend_set  = 1'b1;
                    pend_code = 3'd4;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            FINISH: if (byte_end) begin
                state_n = IDLE;
                fin_err = (err_pend != 3'd0);
                fin_ok  = (err_pend == 3'd0);
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 16'd0;
            sec_q     <= 32'd0;
            err_pend  <= 3'd0;
            sdCs      <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
            errCode   <= 3'd0;
            byteIndex <= 9'd0;
        end else begin
            state <= state_n;
            done  <= fin_ok;
            error <= fin_err;
            sdCs  <= (state_n == IDLE) || (state_n == FINISH);
            if (accept) begin
                sec_q    <= sector;
                errCode  <= 3'd0;
                err_pend <= 3'd0;
            end
            if (pend_set) err_pend <= pend_code;
            if (fin_err)  errCode  <= err_pend;
            if (cnt_clr)      cnt <= 16'd0;
            else if (cnt_inc) cnt <= cnt + 16'd1;
            // Index runs one byte ahead of the shifter and saturates at 511.
            if (state_n == IDLE)
                byteIndex <= 9'd0;
            else if (idx_inc && byteIndex != 9'd511)
                byteIndex <= byteIndex + 9'd1;
        end
    end

    // SPI mode 0: sdClk low for CLK_DIV cycles, high for CLK_DIV cycles; MISO sampled on the
    // rising transition, MOSI advanced on the falling transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            active <= 1'b0;
            div    <= 8'd0;
            bitc   <= 3'd0;
            sdClk  <= 1'b0;
            sh     <= 8'hFF;
            rx     <= 8'h00;
        end else if (load) begin
            active <= 1'b1;
            div    <= 8'd0;
            bitc   <= 3'd0;
            sdClk  <= 1'b0;
            sh     <= tx;
        end else if (active) begin
            if (div == DIV_LAST) begin
                div <= 8'd0;
                if (!sdClk) begin
                    sdClk <= 1'b1;
                    rx    <= {rx[6:0], sdMiso};
                end else begin
                    sdClk <= 1'b0;
                    if (bitc == 3'd7) begin
                        active <= 1'b0;
                    end else begin
                        sh   <= {sh[6:0], 1'b1};
                        bitc <= bitc + 3'd1;
                    end
                end
            end else begin
                div <= div + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_sd_block_writer.sv
// Purpose: directed bench for sd_block_writer with a byte-level SD card model and payload source.
// Latency: checks whole-transfer cycle counts against 32 clk per byte (CLK_DIV=2).
// Backpressure: exercises start while busy and start in the done cycle.
module tb_sd_block_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] sector;
    logic [8:0]  byteIndex;
    logic [7:0]  byteData = 8'h00;
    logic        busy, done, error;
    logic [2:0]  errCode;
    logic        sdClk, sdMosi, sdCs;
    logic        sdMiso = 1'b1;

    always #5 clk = ~clk;

    sd_block_writer #(.CLK_DIV(2), .R1_POLL_MAX(8), .BUSY_POLL_MAX(4)) dut (
        .clk(clk), .rst(rst), .start(start), .sector(sector),
        .byteIndex(byteIndex), .byteData(byteData),
        .busy(busy), .done(done), .error(error), .errCode(errCode),
        .sdClk(sdClk), .sdMosi(sdMosi), .sdMiso(sdMiso), .sdCs(sdCs)
    );

    int nvec = 0;
    int nfail = 0;

    // card behaviour for the current transaction
    int         r1_delay   = 0;
    logic [7:0] r1_val     = 8'h00;
    logic [7:0] dresp_val  = 8'h05;
    int         busy_zeros = 0;

    // card model state
    logic [7:0] log_mem [0:1023];
    int         nlog = 0, nbits = 0, ndone = 0, nerr = 0, fin_clks = 0;
    int         total_rises = 0, mosi_viol = 0;
    logic [7:0] rxsh = 8'h00, cur = 8'hFF;
    logic       prev_clk = 1'b0, prev_cs = 1'b1, prev_mosi = 1'b1;
    logic [8:0] idx_at_fin = 9'd0;

    // Card reply for transaction byte k (0 = the PRE byte).
    function automatic logic [7:0] resp(input int k);
        int rp;
        rp = 7 + r1_delay;
        if (k < rp)        return 8'hFF;
        if (k == rp)       return r1_val;
        if (k == rp + 517) return dresp_val;
        if (k > rp + 517 && k <= rp + 517 + busy_zeros) return 8'h00;
        return 8'hFF;
    endfunction

    always @(posedge clk) begin
        byteData <= byteIndex[7:0];
        if (!sdCs && prev_cs) begin
            nlog = 0; nbits = 0; cur = 8'hFF; ndone = 0; nerr = 0; fin_clks = 0;
            sdMiso <= 1'b1;
        end
        if (sdCs && !prev_cs) idx_at_fin = byteIndex;
        if (sdClk && !prev_clk) begin
            total_rises++;
            if (sdCs) fin_clks++;
            rxsh = {rxsh[6:0], sdMosi};
            nbits++;
            if (nbits == 8) begin
                if (nlog < 1024) log_mem[nlog] = rxsh;
                nlog++;
                nbits = 0;
            end
        end
        if (!sdClk && prev_clk) begin
            if (nbits == 0) begin
                cur = resp(nlog);
                sdMiso <= cur[7];
            end else begin
                sdMiso <= cur[3'(7 - nbits)];
            end
        end
        if (sdClk && prev_clk && sdMosi !== prev_mosi) mosi_viol++;
        if (done)  ndone++;
        if (error) nerr++;
        prev_clk  = sdClk;
        prev_cs   = sdCs;
        prev_mosi = sdMosi;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one start, optionally re-pulse start while busy (inject_at) or in the done cycle (poke).
    task automatic run_txn(input logic [31:0] sec, input int inject_at, input bit poke, output int cyc);
        int n;
        bit fin;
        n = 0;
        fin = 1'b0;
        sector = sec;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (!fin && n < 20000) begin
            @(posedge clk); #1;
            n++;
            if (n == inject_at) begin
                start = 1'b1;
                sector = ~sec;
            end else begin
                start = 1'b0;
            end
            if (done || error) fin = 1'b1;
        end
        cyc = n;
        if (poke) begin
            start = 1'b1;
            sector = 32'hCAFE0000;
        end
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        int cyc, bad, n, rises;
        rst = 1'b1; start = 1'b0; sector = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {sdCs, sdClk, sdMosi, busy, done, error}, 6'b101000);
        check("reset_errcode_index", {errCode, byteIndex}, 12'h000);
        rst = 1'b0;
        @(posedge clk); #1;

        // happy path: R1 after 2 polls, response 0x05, 3 busy bytes then release
        r1_delay = 2; r1_val = 8'h00; dresp_val = 8'h05; busy_zeros = 3;
        run_txn(32'h00001234, -1, 1'b0, cyc);
        check("happy_cycles", cyc, 32 * 532);
        check("happy_bytes", nlog, 532);
        check("happy_cmd", {log_mem[1], log_mem[2], log_mem[3], log_mem[4], log_mem[5], log_mem[6]},
              48'h58_00_00_12_34_FF);
        check("happy_pre_r1_gap", {log_mem[0], log_mem[7], log_mem[8], log_mem[9], log_mem[10]},
              40'hFF_FF_FF_FF_FF);
        check("happy_token", log_mem[11], 8'hFE);
        bad = 0;
        for (int i = 0; i < 512; i++) if (log_mem[12 + i] !== 8'(i)) bad++;
        check("happy_data_bad_bytes", bad, 0);
        check("happy_crc_dresp", {log_mem[524], log_mem[525], log_mem[526]}, 24'hFF_FF_FF);
        check("happy_pulses", {ndone[7:0], nerr[7:0]}, 16'h0100);
        check("happy_errcode", errCode, 3'd0);
        check("happy_finish_clocks", fin_clks, 8);
        check("happy_index_at_finish", idx_at_fin, 9'd511);
        check("happy_idle_bus", {sdCs, sdClk, sdMosi, busy}, 4'b1010);

        // R1 nonzero
        r1_delay = 0; r1_val = 8'h04;
        run_txn(32'h00000010, -1, 1'b0, cyc);
        check("r1err_cycles", cyc, 32 * 9);
        check("r1err_bytes", nlog, 9);
        check("r1err_pulses", {ndone[7:0], nerr[7:0]}, 16'h0001);
        check("r1err_errcode", errCode, 3'd2);
        check("r1err_finish_clocks", fin_clks, 8);

        // data rejected
        r1_val = 8'h00; dresp_val = 8'h0B; busy_zeros = 3;
        run_txn(32'h00000020, -1, 1'b0, cyc);
        check("reject_cycles", cyc, 32 * 526);
        check("reject_bytes", nlog, 526);
        check("reject_pulses", {ndone[7:0], nerr[7:0]}, 16'h0001);
        check("reject_errcode", errCode, 3'd3);

        // R1 timeout: MISO stays 0xFF
        r1_delay = 20; dresp_val = 8'h05;
        run_txn(32'h00000030, -1, 1'b0, cyc);
        check("r1to_cycles", cyc, 32 * 16);
        check("r1to_bytes", nlog, 16);
        check("r1to_errcode", errCode, 3'd1);
        check("r1to_finish_clocks", fin_clks, 8);

        // busy timeout: MISO stays 0x00 after the data response
        r1_delay = 0; busy_zeros = 10;
        run_txn(32'h00000040, -1, 1'b0, cyc);
        check("busyto_cycles", cyc, 32 * 530);
        check("busyto_bytes", nlog, 530);
        check("busyto_pulses", {ndone[7:0], nerr[7:0]}, 16'h0001);
        check("busyto_errcode", errCode, 3'd4);

        // start while busy and start in the done cycle are both ignored
        busy_zeros = 0;
        run_txn(32'hDEADBEEF, 20, 1'b1, cyc);
        check("ign_cycles", cyc, 32 * 527);
        check("ign_cmd", {log_mem[1], log_mem[2], log_mem[3], log_mem[4], log_mem[5], log_mem[6]},
              48'h58_DE_AD_BE_EF_FF);
        check("ign_pulses", {ndone[7:0], nerr[7:0]}, 16'h0100);
        check("ign_errcode_cleared", errCode, 3'd0);
        check("ign_done_cycle_start", {busy, sdCs}, 2'b01);
        rises = total_rises;
        repeat (40) @(posedge clk);
        #1;
        check("ign_no_new_clocks", total_rises - rises, 0);

        // reset during DATA byte 100
        sector = 32'h0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (byteIndex != 9'd101 && n < 10000) begin
            @(posedge clk); #1;
            n++;
        end
        check("rst_reached_byte100", byteIndex, 9'd101);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_bus_next_edge", {sdCs, sdClk, sdMosi, busy}, 4'b1010);
        rst = 1'b0;
        rises = total_rises;
        repeat (100) @(posedge clk);
        #1;
        check("rst_no_pulses", {ndone[7:0], nerr[7:0]}, 16'h0000);
        check("rst_no_clocks", total_rises - rises, 0);
        check("rst_index_errcode", {byteIndex, errCode}, 12'h000);
        check("mosi_stable_while_sclk_high", mosi_viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/sd_block_writer.md
SD_BLOCK_WRITER -- requirements
Module: sd_block_writer

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2: clk cycles per sdClk half-period (legal range 1..255).
REQ-002 SHALL have parameter R1_POLL_MAX, default 8: maximum 0xFF-padded bytes to wait for the R1 response.
REQ-003 SHALL have parameter BUSY_POLL_MAX, default 65535: maximum bytes to wait for card busy release.
REQ-004 SHALL have port clk, input, 1 bit: single system clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port start, input, 1 bit: one-cycle request to write one block; ignored while busy=1.
REQ-007 SHALL have port sector, input, 32 bits: block address, captured on an accepted start.
REQ-008 SHALL have port byteIndex, output, 9 bits: index of the payload byte requested from the source.
REQ-009 SHALL have port byteData, input, 8 bits: payload byte; source returns data for byteIndex with 1-cycle latency.
REQ-010 SHALL have port busy, output, 1 bit: high from the cycle after an accepted start until done or error.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse on successful completion.
REQ-012 SHALL have port error, output, 1 bit: one-cycle pulse on failure; done is not asserted on failure.
REQ-013 SHALL have port errCode, output, 3 bits: cause of last error (1 R1 timeout, 2 R1 nonzero, 3 data rejected, 4 busy timeout); holds until the next start.
REQ-014 SHALL have ports sdClk (out), sdMosi (out), sdMiso (in), sdCs (out), 1 bit each: SPI mode 0 master to an already-initialised card in SPI mode.

Function
REQ-015 SHALL shift bytes MSB first; sdMosi changes only while sdClk is low; sdMiso is sampled on the clk cycle in which sdClk rises.
REQ-016 SHALL time one bit as 2*CLK_DIV clk cycles and one byte as 16*CLK_DIV clk cycles, with no idle gap between bytes.
REQ-017 SHALL hold sdClk low and sdMosi high whenever no byte is being shifted.
REQ-018 SHALL run states IDLE -> PRE -> CMD -> R1 -> GAP -> TOKEN -> DATA -> CRC -> DRESP -> BUSY -> FINISH -> IDLE.
REQ-019 PRE: assert sdCs low, then send one 0xFF byte.
REQ-020 CMD: send the six bytes 0x58, sector[31:24], sector[23:16], sector[15:8], sector[7:0], 0xFF.
REQ-021 R1: send 0xFF bytes until a received byte has bit7=0; that byte is R1.
REQ-022 R1 SHALL continue with GAP when R1=0x00, raise errCode 2 when R1 is nonzero, and raise errCode 1 after R1_POLL_MAX bytes with bit7=1.
REQ-023 GAP: send one 0xFF byte; TOKEN: send 0xFE.
REQ-024 DATA: send 512 bytes, where byte n is the byteData returned for byteIndex=n.
REQ-025 byteIndex SHALL be stable at n for at least 2 clk cycles before byte n is loaded into the shifter.
REQ-026 byteIndex SHALL reach 511 and stay there until IDLE; it does not wrap to 0 during the block.
REQ-027 CRC: send 0xFF, 0xFF. DRESP: send 0xFF and capture the received byte.
REQ-028 DRESP SHALL continue with BUSY when (byte & 0x1F)=0x05, otherwise raise errCode 3.
REQ-029 BUSY: send 0xFF bytes until a received byte is nonzero, which means the card is no longer busy; raise errCode 4 after BUSY_POLL_MAX zero bytes.
REQ-030 FINISH: deassert sdCs high, then send one 0xFF byte (8 clocks) with sdCs high, then pulse done.
REQ-031 Every error path SHALL first perform FINISH (sdCs high plus 8 clocks), then pulse error instead of done.
REQ-032 busy SHALL fall in the same cycle that done or error pulses.
REQ-033 start asserted in the same cycle as done or error SHALL be ignored.
REQ-034 The total transfer SHALL be 1 + 6 + nR1 + 1 + 1 + 512 + 2 + 1 + nBusy + 1 bytes.

Reset
REQ-035 While rst=1 the block SHALL drive sdCs=1, sdClk=0, sdMosi=1, busy=0, done=0, error=0, errCode=0, byteIndex=0, state IDLE.
REQ-036 rst asserted mid-transfer SHALL abort it, with sdCs high and sdClk low from the next clk edge; no done or error is pulsed.

Verification
REQ-037 Happy path: CLK_DIV=2, sector=0x00001234, card model R1=0x00 after 2 polls, response 0x05, busy 3 bytes, source byte n = n[7:0] -> MOSI shows 58 00 00 12 34 FF, then FE, 00..FF twice, FF FF; done pulses once; errCode=0.
REQ-038 R1 error: card returns R1=0x04 -> no FE token sent; sdCs high plus 8 clocks; error pulses with errCode=2.
REQ-039 Data rejected: response 0x0B -> error pulses with errCode=3; busy polling is skipped.
REQ-040 Timeouts: MISO stuck 0xFF during R1 -> errCode=1 after 8 bytes; MISO stuck 0x00 during BUSY with BUSY_POLL_MAX=4 -> errCode=4.
REQ-041 Reset and ignored start: rst pulsed during DATA byte 100 -> sdCs=1 next edge and busy=0; a second start while busy -> no effect; start in the done cycle -> ignored.
